// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Funnels NUM_CONSUMERS per-thread LSU request lanes onto a single external
//   data-memory channel. Only one transaction is in flight at a time.
//
//   Handshake (both sides): a requester raises valid and holds it, together
//   with its address/data, until it sees the matching ready. On the memory
//   side the arbiter keeps mem_*_valid and its address/data stable until
//   mem_*_ready is sampled high. On the consumer side ready stays high until
//   the lane drops the matching valid. After that, ready falls on the next edge.
//
//   Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration.
//   The search starts at rr_ptr and wraps. Without it, arbitration is fixed
//   priority and the lowest lane index wins.
//
// Ports
//   clk, reset                    clock / synchronous active-high reset
//   consumer_read_valid/address   per-lane read request, address
//   consumer_read_ready/data      per-lane read completion, returned word
//   consumer_write_valid/address/data  per-lane write request
//   consumer_write_ready          per-lane write completion
//   mem_read_valid/address        read request to memory
//   mem_read_ready/data           memory read completion, returned word
//   mem_write_valid/address/data  write request to memory
//   mem_write_ready               memory write completion
//   busy                          high whenever the FSM is not IDLE
module data_mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready,
    output logic                               busy
);

    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_is_read;   // selects which valid ends RELEASE

    // Per-lane views of the flattened buses.
    logic [ADDR_BITS-1:0] rd_addr_lane [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] wr_addr_lane [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] wr_data_lane [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] rd_data_q    [NUM_CONSUMERS];

    always_comb begin
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            rd_addr_lane[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
            wr_addr_lane[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
            wr_data_lane[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    always_comb begin
        consumer_read_data = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            consumer_read_data[i*DATA_BITS +: DATA_BITS] = rd_data_q[i];
        end
    end

    logic [NUM_CONSUMERS-1:0] lane_request;
    logic                     grant_found;
    logic [IDX_W-1:0]         grant_sel;

    assign lane_request = consumer_read_valid | consumer_write_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W:0]   probe_sum;
    logic [IDX_W-1:0] probe_idx;

    // Scan offsets from highest to lowest so that the first lane at or after
    // rr_ptr (lowest offset) is the one left in grant_sel.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        probe_sum   = '0;
        probe_idx   = '0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            probe_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (probe_sum >= (IDX_W+1)'(NUM_CONSUMERS)) begin
                probe_sum = probe_sum - (IDX_W+1)'(NUM_CONSUMERS);
            end
            probe_idx = probe_sum[IDX_W-1:0];
            if (lane_request[probe_idx]) begin
                grant_found = 1'b1;
                grant_sel   = probe_idx;
            end
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest requesting lane.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            if (lane_request[k]) begin
                grant_found = 1'b1;
                grant_sel   = IDX_W'(k);
            end
        end
    end
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            grant_idx            <= '0;
            grant_is_read        <= 1'b0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                rd_data_q[i] <= '0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr               <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        grant_idx <= grant_sel;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr <= (grant_sel == IDX_W'(NUM_CONSUMERS - 1)) ?
                                  '0 : grant_sel + 1'b1;
`endif
                        // Read takes precedence when a lane raises both.
                        if (consumer_read_valid[grant_sel]) begin
                            grant_is_read    <= 1'b1;
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= rd_addr_lane[grant_sel];
                            state            <= READ_WAIT;
                        end else begin
                            grant_is_read     <= 1'b0;
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= wr_addr_lane[grant_sel];
                            mem_write_data    <= wr_data_lane[grant_sel];
                            state             <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        rd_data_q[grant_idx]           <= mem_read_data;
                        consumer_read_ready[grant_idx] <= 1'b1;
                        mem_read_valid                 <= 1'b0;
                        state                          <= RELEASE;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        consumer_write_ready[grant_idx] <= 1'b1;
                        mem_write_valid                 <= 1'b0;
                        state                           <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Read data is left in place; only the ready bit drops.
                    if (grant_is_read ? !consumer_read_valid[grant_idx]
                                      : !consumer_write_valid[grant_idx]) begin
                        consumer_read_ready  <= '0;
                        consumer_write_ready <= '0;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: directed scenarios plus randomized batches.
// Lane drivers and a memory responder produce traffic. A transaction-level
// reference model predicts the service order and the read data. A monitor
// compares the DUT against those predictions.
module tb_data_mem_arbiter;
  localparam int NC = 4;
  localparam int AB = 8;
  localparam int DB = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC-1:0]    consumer_read_valid;
  logic [NC*AB-1:0] consumer_read_address;
  logic [NC-1:0]    consumer_read_ready;
  logic [NC*DB-1:0] consumer_read_data;
  logic [NC-1:0]    consumer_write_valid;
  logic [NC*AB-1:0] consumer_write_address;
  logic [NC*DB-1:0] consumer_write_data;
  logic [NC-1:0]    consumer_write_ready;
  logic             mem_read_valid;
  logic [AB-1:0]    mem_read_address;
  logic             mem_read_ready;
  logic [DB-1:0]    mem_read_data;
  logic             mem_write_valid;
  logic [AB-1:0]    mem_write_address;
  logic [DB-1:0]    mem_write_data;
  logic             mem_write_ready;
  logic             busy;

  data_mem_arbiter #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready),
    .busy                   (busy)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] lane;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t exp_q[$];
  txn_t inflight_q[$];

  logic [7:0] phys_mem [256];
  logic [7:0] ref_mem  [256];
  logic [7:0] lane_raddr [NC];
  logic [7:0] lane_waddr [NC];
  logic [7:0] lane_wdata [NC];
  int         lane_hold  [NC];
  int         m_rr = 0;
  bit         resp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Services every pending op of a simultaneously issued batch: pick a lane
  // by the arbitration rule, take its read before its write, repeat.
  task automatic model_batch(input logic [NC-1:0] rm, input logic [NC-1:0] wm);
    logic [NC-1:0] pr;
    logic [NC-1:0] pw;
    int g;
    txn_t e;
    pr = rm;
    pw = wm;
    while ((pr | pw) != '0) begin
      g = -1;
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 0; k < NC; k++)
        if (g < 0 && (pr[(m_rr + k) % NC] || pw[(m_rr + k) % NC])) g = (m_rr + k) % NC;
`else
      for (int k = 0; k < NC; k++)
        if (g < 0 && (pr[k] || pw[k])) g = k;
`endif
      e.lane = 2'(g);
      if (pr[g]) begin
        e.rd = 1'b1; e.addr = lane_raddr[g]; e.data = ref_mem[e.addr]; pr[g] = 1'b0;
      end else begin
        e.rd = 1'b0; e.addr = lane_waddr[g]; e.data = lane_wdata[g];
        ref_mem[e.addr] = e.data; pw[g] = 1'b0;
      end
      exp_q.push_back(e);
      m_rr = (g + 1) % NC;
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int rd_cnt;
    int wr_cnt;
    rd_cnt = -1; wr_cnt = -1;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    forever begin
      @(negedge clk);
      mem_read_ready = 1'b0;
      mem_write_ready = 1'b0;
      if (reset || !resp_en) begin
        rd_cnt = -1; wr_cnt = -1;
      end else begin
        if (mem_read_valid) begin
          if (rd_cnt < 0) rd_cnt = $urandom_range(0, 3);
          if (rd_cnt == 0) begin
            mem_read_ready = 1'b1;
            mem_read_data = phys_mem[mem_read_address];
            rd_cnt = -1;
          end else rd_cnt--;
        end else if ($urandom_range(0, 7) == 0) begin
          // stray ready with junk data; must be ignored
          mem_read_ready = 1'b1;
          mem_read_data = 8'($urandom);
        end
        if (mem_write_valid) begin
          if (wr_cnt < 0) wr_cnt = $urandom_range(0, 3);
          if (wr_cnt == 0) begin
            mem_write_ready = 1'b1;
            phys_mem[mem_write_address] = mem_write_data;
            wr_cnt = -1;
          end else wr_cnt--;
        end else if ($urandom_range(0, 7) == 0) begin
          mem_write_ready = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [NC-1:0] p_crr, p_cwr, p_rv, p_wv;
    logic          p_mrv, p_mwv, acc_pend;
    logic [7:0]    cur_addr, cur_wdata;
    logic [7:0]    last_rd [NC];
    logic [2*NC-1:0] rise, exp_vec;
    txn_t e;
    p_crr = '0; p_cwr = '0; p_rv = '0; p_wv = '0;
    p_mrv = 1'b0; p_mwv = 1'b0; acc_pend = 1'b0;
    cur_addr = '0; cur_wdata = '0;
    for (int i = 0; i < NC; i++) last_rd[i] = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        exp_q.delete(); inflight_q.delete();
        acc_pend = 1'b0;
        for (int i = 0; i < NC; i++) last_rd[i] = '0;
        p_crr = '0; p_cwr = '0; p_mrv = 1'b0; p_mwv = 1'b0;
        p_rv = consumer_read_valid; p_wv = consumer_write_valid;
        continue;
      end

      chk("one_mem_valid", 32'(mem_read_valid & mem_write_valid), 0);
      chk("one_cons_ready", 32'($countones({consumer_read_ready, consumer_write_ready}) <= 1), 1);
      if (mem_read_valid || mem_write_valid || (|consumer_read_ready) || (|consumer_write_ready))
        chk("busy_active", 32'(busy), 1);

      // new memory transaction: must match the next predicted one
      if ((mem_read_valid && !p_mrv) || (mem_write_valid && !p_mwv)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mem_req", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("mem_op_is_read", 32'(mem_read_valid), 32'(e.rd));
          chk("mem_addr", 32'(mem_read_valid ? mem_read_address : mem_write_address), 32'(e.addr));
          if (!e.rd) chk("mem_wdata", 32'(mem_write_data), 32'(e.data));
          inflight_q.push_back(e);
        end
        cur_addr = mem_read_valid ? mem_read_address : mem_write_address;
        cur_wdata = mem_write_data;
      end else begin
        if (mem_read_valid) chk("rd_addr_stable", 32'(mem_read_address), 32'(cur_addr));
        if (mem_write_valid) begin
          chk("wr_addr_stable", 32'(mem_write_address), 32'(cur_addr));
          chk("wr_data_stable", 32'(mem_write_data), 32'(cur_wdata));
        end
      end

      // consumer ready must appear exactly one cycle after memory accepts
      rise = {consumer_read_ready, consumer_write_ready} & ~{p_crr, p_cwr};
      if (acc_pend) begin
        if (inflight_q.size() == 0) begin
          chk("ready_without_txn", 1, 0);
        end else begin
          e = inflight_q.pop_front();
          exp_vec = e.rd ? ((2*NC)'(1) << (NC + int'(e.lane))) : ((2*NC)'(1) << int'(e.lane));
          chk("cons_ready_lane", 32'(rise), 32'(exp_vec));
          if (e.rd) begin
            chk("cons_rdata", 32'(consumer_read_data[int'(e.lane)*DB +: DB]), 32'(e.data));
            last_rd[e.lane] = e.data;
          end
        end
        acc_pend = 1'b0;
      end else begin
        chk("no_spurious_ready", 32'(rise), 0);
      end
      if ((mem_read_valid && mem_read_ready) || (mem_write_valid && mem_write_ready)) acc_pend = 1'b1;

      // ready holds while valid is held, drops one edge after valid drops
      for (int i = 0; i < NC; i++) begin
        if (p_crr[i]) chk("rd_ready_release", 32'(consumer_read_ready[i]), 32'(p_rv[i]));
        if (p_cwr[i]) chk("wr_ready_release", 32'(consumer_write_ready[i]), 32'(p_wv[i]));
        chk("rd_data_hold", 32'(consumer_read_data[i*DB +: DB]), 32'(last_rd[i]));
      end

      p_crr = consumer_read_ready; p_cwr = consumer_write_ready;
      p_rv = consumer_read_valid; p_wv = consumer_write_valid;
      p_mrv = mem_read_valid; p_mwv = mem_write_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic lane_proc(input int i, input bit dr, input bit dw, input int hold);
    int t;
    if (dr) begin
      t = 0;
      while (consumer_read_ready[i] !== 1'b1 && t < 400) begin @(negedge clk); t++; end
      checks++;
      if (t >= 400) begin
        errors++;
        $display("FAIL lane%0d_read_timeout: read_ready=%0b after %0d cycles, required 1", i, consumer_read_ready[i], t);
      end
      repeat (hold) @(negedge clk);
      consumer_read_valid[i] = 1'b0;
    end
    if (dw) begin
      t = 0;
      while (consumer_write_ready[i] !== 1'b1 && t < 400) begin @(negedge clk); t++; end
      checks++;
      if (t >= 400) begin
        errors++;
        $display("FAIL lane%0d_write_timeout: write_ready=%0b after %0d cycles, required 1", i, consumer_write_ready[i], t);
      end
      repeat (hold) @(negedge clk);
      consumer_write_valid[i] = 1'b0;
    end
  endtask

  task automatic set_lane_buses();
    for (int i = 0; i < NC; i++) begin
      consumer_read_address[i*AB +: AB] = lane_raddr[i];
      consumer_write_address[i*AB +: AB] = lane_waddr[i];
      consumer_write_data[i*DB +: DB] = lane_wdata[i];
    end
  endtask

  task automatic run_batch(input logic [NC-1:0] rm, input logic [NC-1:0] wm);
    @(negedge clk);
    set_lane_buses();
    model_batch(rm, wm);
    consumer_read_valid = rm;
    consumer_write_valid = wm;
    fork
      lane_proc(0, rm[0], wm[0], lane_hold[0]);
      lane_proc(1, rm[1], wm[1], lane_hold[1]);
      lane_proc(2, rm[2], wm[2], lane_hold[2]);
      lane_proc(3, rm[3], wm[3], lane_hold[3]);
    join
    repeat (2) @(negedge clk);
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < NC; i++) begin
      lane_raddr[i] = 8'($urandom_range(0, 15));
      lane_waddr[i] = 8'($urandom_range(0, 15));
      lane_wdata[i] = 8'($urandom);
      lane_hold[i]  = $urandom_range(0, 3);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_read_valid"}, 32'(mem_read_valid), 0);
    chk({tag, "_mem_write_valid"}, 32'(mem_write_valid), 0);
    chk({tag, "_mem_read_address"}, 32'(mem_read_address), 0);
    chk({tag, "_mem_write_address"}, 32'(mem_write_address), 0);
    chk({tag, "_mem_write_data"}, 32'(mem_write_data), 0);
    chk({tag, "_read_ready"}, 32'(consumer_read_ready), 0);
    chk({tag, "_write_ready"}, 32'(consumer_write_ready), 0);
    chk({tag, "_read_data"}, 32'(consumer_read_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    logic [NC-1:0] rm, wm;
    reset = 1'b1;
    consumer_read_valid = '0; consumer_write_valid = '0;
    consumer_read_address = '0; consumer_write_address = '0; consumer_write_data = '0;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = 8'($urandom);
      ref_mem[i] = phys_mem[i];
    end
    for (int i = 0; i < NC; i++) begin
      lane_raddr[i] = '0; lane_waddr[i] = '0; lane_wdata[i] = '0; lane_hold[i] = 0;
    end
    repeat (3) @(negedge clk);
    #2;
    check_zero("reset");
    reset = 1'b0;
    resp_en = 1'b1;

    // single read, lane 2, addr 0x10 -> 0x5A
    phys_mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
    randomize_lanes();
    lane_raddr[2] = 8'h10;
    run_batch(4'b0100, 4'b0000);
    chk("idle_after_read", 32'(busy), 0);

    // single write, lane 0, 0x20 <- 0xC3, then read it back on lane 1
    lane_waddr[0] = 8'h20; lane_wdata[0] = 8'hC3;
    run_batch(4'b0000, 4'b0001);
    lane_raddr[1] = 8'h20;
    run_batch(4'b0010, 4'b0000);

    // all four lanes read at once
    randomize_lanes();
    run_batch(4'b1111, 4'b0000);

    // lane 1 raises read and write together
    randomize_lanes();
    lane_waddr[1] = lane_raddr[1];
    run_batch(4'b0010, 4'b0010);

    // reset while waiting on memory
    resp_en = 1'b0;
    randomize_lanes();
    @(negedge clk);
    set_lane_buses();
    model_batch(4'b0100, 4'b0000);
    consumer_read_valid[2] = 1'b1;
    t = 0;
    while (mem_read_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("reset_test_read_issued", 32'(mem_read_valid), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    consumer_read_valid = '0;
    @(negedge clk);
    #2;
    check_zero("midreset");
    reset = 1'b0;
    m_rr = 0;
    resp_en = 1'b1;
    run_batch(4'b0100, 4'b0000);

    // lane 3 holds ready 5 cycles while lane 0 waits
    randomize_lanes();
    @(negedge clk);
    set_lane_buses();
    model_batch(4'b1000, 4'b0000);
    consumer_read_valid[3] = 1'b1;
    t = 0;
    while (mem_read_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("lane3_read_issued", 32'(mem_read_valid), 1);
    model_batch(4'b0001, 4'b0000);
    consumer_read_valid[0] = 1'b1;
    fork
      lane_proc(3, 1'b1, 1'b0, 5);
      lane_proc(0, 1'b1, 1'b0, 0);
    join
    repeat (2) @(negedge clk);

    // randomized batches
    for (int n = 0; n < 40; n++) begin
      randomize_lanes();
      rm = 4'($urandom_range(0, 15));
      wm = 4'($urandom_range(0, 15));
      if ((rm | wm) == '0) rm = 4'b0001;
      run_batch(rm, wm);
    end

    repeat (5) @(negedge clk);
    #2;
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("inflight_drained", 32'(inflight_q.size()), 0);
    chk("final_idle", 32'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
